// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with memory timeout, trap state and retire counter.
module multicycle_control_unit #(
  parameter int unsigned OP_WIDTH       = 7,
  parameter int unsigned FUNCT3_WIDTH   = 3,
  parameter int unsigned ALU_CTRL_WIDTH = 3,
  parameter int unsigned IMM_SRC_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  input  logic                      N,
  input  logic                      C,
  input  logic                      V,
  input  logic                      MemReady,
  output logic                      MemReq,
  output logic                      MemWrite,
  output logic                      AdrSrc,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      RegWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic                      Trap,
  output logic [1:0]                TrapCause,
  output logic [CNT_WIDTH-1:0]      InstRet
);

  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_TRAP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WAIT_W-1:0]      r_wait;
  logic [1:0]             r_cause;
  logic [CNT_WIDTH-1:0]   r_instret;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [2:0] w_alu_op;
  logic       w_alu_bad;
  logic       w_take;
  logic       w_br_bad;
  logic       w_timeout;
  logic       w_mem_wait;
  logic [1:0] w_cause_set;
  logic [2:0] w_alu3;
  logic [1:0] w_imm2;

  assign w_op      = 7'(op);
  assign w_f3      = 3'(funct3);
  assign w_timeout = (MEM_TIMEOUT != 0) && !MemReady && (r_wait == WAIT_W'(TO_LAST));

  // funct3 -> ALU operation; funct7_5 selects SUB only for register-register ops
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_bad = 1'b0;
    case (w_f3)
      3'b000:  w_alu_op = (funct7_5 && (r_state == S_EXECR)) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_op = ALU_AND;
      3'b110:  w_alu_op = ALU_OR;
      3'b100:  w_alu_op = ALU_XOR;
      3'b010:  w_alu_op = ALU_SLT;
      3'b001:  w_alu_op = ALU_SLL;
      3'b101:  w_alu_op = ALU_SRL;
      default: w_alu_bad = 1'b1;
    endcase
  end

  // branch condition from flags of A-B; C is carry-out so !C means A <u B
  always_comb begin
    w_take   = 1'b0;
    w_br_bad = 1'b0;
    case (w_f3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = !Zero;
      3'b100:  w_take = N ^ V;
      3'b101:  w_take = !(N ^ V);
      3'b110:  w_take = !C;
      3'b111:  w_take = C;
      default: w_br_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    w_alu3       = ALU_ADD;
    w_imm2       = 2'b00;
    Trap         = 1'b0;
    w_mem_wait   = 1'b0;
    w_cause_set  = CAUSE_NONE;
    case (r_state)
      S_FETCH: begin
        MemReq     = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        w_mem_wait = !MemReady;
        if (MemReady) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_cause_set  = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        w_imm2  = (w_op == OP_JAL) ? 2'b11 : 2'b10;
        case (w_op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_BRANCH:         w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          default: begin
            w_state_next = S_TRAP;
            w_cause_set  = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        w_imm2       = (w_op == OP_STORE) ? 2'b01 : 2'b00;
        w_state_next = (w_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq     = 1'b1;
        AdrSrc     = 1'b1;
        w_mem_wait = !MemReady;
        if (MemReady) begin
          w_state_next = S_MEMWB;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_cause_set  = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq     = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        w_mem_wait = !MemReady;
        if (MemReady) begin
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_cause_set  = CAUSE_TIMEOUT;
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu3  = w_alu_op;
        if (w_alu_bad) begin
          w_state_next = S_TRAP;
          w_cause_set  = CAUSE_ILLEGAL;
        end else begin
          w_state_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        w_alu3  = ALU_SUB;
        if (w_br_bad) begin
          w_state_next = S_TRAP;
          w_cause_set  = CAUSE_ILLEGAL;
        end else begin
          PCWrite      = w_take;
          w_state_next = S_FETCH;
        end
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        PCWrite      = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        PCWrite      = 1'b1;
        w_state_next = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        Trap = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // retirement is any arrival in FETCH from elsewhere; only completing states lead there
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_mem_wait ? r_wait + WAIT_W'(1) : '0;
      if (r_state != S_TRAP) r_cause <= w_cause_set;
      if ((w_state_next == S_FETCH) && (r_state != S_FETCH)) r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

  assign ALUControl = ALU_CTRL_WIDTH'(w_alu3);
  assign ImmSrc     = IMM_SRC_WIDTH'(w_imm2);
  assign TrapCause  = r_cause;
  assign InstRet    = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level model predicts
// the control word of every cycle; a few literal checks pin cycle counts and InstRet.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_BAD = 7'b0110111;
  localparam logic [2:0] A_ADD  = 3'b000;
  localparam logic [2:0] A_SUB  = 3'b001;

  logic          CLK, RST;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          funct7_5, Zero, N, C, V, MemReady;
  logic          MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]    ALUControl;
  logic [1:0]    ImmSrc;
  logic          Trap;
  logic [1:0]    TrapCause;
  logic [CW-1:0] InstRet;

  multicycle_control_unit #(
    .OP_WIDTH(7), .FUNCT3_WIDTH(3), .ALU_CTRL_WIDTH(3), .IMM_SRC_WIDTH(2),
    .CNT_WIDTH(CW), .MEM_TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .N(N), .C(C), .V(V), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .Trap(Trap),
    .TrapCause(TrapCause), .InstRet(InstRet)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       mreq, mwr, adr, irw, pcw, rw;
    logic [1:0] res, sa, sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       trap;
    logic [1:0] cause;
    logic [3:0] ret;
  } exp_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_ret = 0;
  int         m_total = 0;
  int         m_cyc = 0;
  logic [1:0] m_cause = 2'b00;
  logic       m_trap = 1'b0;
  logic [2:0] alu_tbl [8];
  logic [2:0] r_f3s [6];
  logic [2:0] b_f3s [6];
  logic [3:0] flag_pat [3];

  function automatic exp_t ctl(input logic mreq, mwr, adr, irw, pcw, rw,
                               input logic [1:0] res, sa, sb,
                               input logic [2:0] alu, input logic [1:0] imm);
    exp_t e;
    e = '0;
    e.mreq = mreq; e.mwr = mwr; e.adr = adr; e.irw = irw; e.pcw = pcw; e.rw = rw;
    e.res = res; e.sa = sa; e.sb = sb; e.alu = alu; e.imm = imm;
    return e;
  endfunction

  function automatic logic br_take(input logic [2:0] f3, input logic fz, fn, fc, fv);
    case (f3)
      3'd0:    return fz;
      3'd1:    return !fz;
      3'd4:    return fn ^ fv;
      3'd5:    return !(fn ^ fv);
      3'd6:    return !fc;
      3'd7:    return fc;
      default: return 1'b0;
    endcase
  endfunction

  // one clock of stimulus; the DUT control word is compared at the falling edge
  task automatic cyc(input string nm, input exp_t e_in, input logic rdy);
    exp_t e, a;
    e       = e_in;
    e.trap  = m_trap;
    e.cause = m_cause;
    e.ret   = CW'(m_ret);
    MemReady = rdy;
    @(negedge CLK);
    a = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
         ALUSrcB, ALUControl, ImmSrc, Trap, TrapCause, InstRet};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %06h required %06h", nm, a, e);
    end
    @(posedge CLK);
    #1;
    m_cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask

  task automatic retire();
    m_ret = (m_ret + 1) % 16;
    m_total++;
  endtask

  task automatic trap_ph(input logic [1:0] cause);
    m_cause = cause;
    m_trap  = 1'b1;
    for (int i = 0; i < 3; i++) cyc("trap", ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,A_ADD,2'b00), 1'b0);
  endtask

  task automatic fetch_ph(input int waits);
    for (int i = 0; i < waits; i++)
      cyc("fetch_wait", ctl(1,0,0,0,0,0,2'b10,2'b00,2'b10,A_ADD,2'b00), 1'b0);
    cyc("fetch", ctl(1,0,0,1,1,0,2'b10,2'b00,2'b10,A_ADD,2'b00), 1'b1);
  endtask

  task automatic decode_ph(input logic [6:0] o);
    cyc("decode", ctl(0,0,0,0,0,0,2'b00,2'b01,2'b01,A_ADD,(o == OP_JAL) ? 2'b11 : 2'b10), 1'b0);
  endtask

  task automatic aluwb_ph();
    cyc("aluwb", ctl(0,0,0,0,0,1,2'b00,2'b00,2'b00,A_ADD,2'b00), 1'b0);
    retire();
  endtask

  // instruction-level model: expected control sequence for one instruction
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input int fw, input int mw);
    logic [2:0] alu;
    logic [1:0] srcb;
    op = o; funct3 = f3; funct7_5 = f7;
    fetch_ph(fw);
    decode_ph(o);
    case (o)
      OP_LD, OP_ST: begin
        cyc("memadr", ctl(0,0,0,0,0,0,2'b00,2'b10,2'b01,A_ADD,(o == OP_ST) ? 2'b01 : 2'b00), 1'b0);
        for (int i = 0; i <= mw; i++)
          cyc((o == OP_ST) ? "memwrite" : "memread",
              ctl(1,(o == OP_ST),1,0,0,0,2'b00,2'b00,2'b00,A_ADD,2'b00), (i == mw));
        if (o == OP_LD) cyc("memwb", ctl(0,0,0,0,0,1,2'b01,2'b00,2'b00,A_ADD,2'b00), 1'b0);
        retire();
      end
      OP_R, OP_I: begin
        srcb = (o == OP_I) ? 2'b01 : 2'b00;
        alu  = alu_tbl[f3];
        if (o == OP_R && f3 == 3'd0 && f7) alu = A_SUB;
        if (f3 == 3'd3) begin
          cyc("exec_illegal", ctl(0,0,0,0,0,0,2'b00,2'b10,srcb,A_ADD,2'b00), 1'b0);
          trap_ph(2'b01);
        end else begin
          cyc("exec", ctl(0,0,0,0,0,0,2'b00,2'b10,srcb,alu,2'b00), 1'b0);
          aluwb_ph();
        end
      end
      OP_BR: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          cyc("branch_illegal", ctl(0,0,0,0,0,0,2'b00,2'b10,2'b00,A_SUB,2'b00), 1'b0);
          trap_ph(2'b01);
        end else begin
          cyc("branch", ctl(0,0,0,0,br_take(f3, Zero, N, C, V),0,2'b00,2'b10,2'b00,A_SUB,2'b00), 1'b0);
          retire();
        end
      end
      OP_JAL: begin
        cyc("jal", ctl(0,0,0,0,1,0,2'b00,2'b01,2'b10,A_ADD,2'b00), 1'b0);
        aluwb_ph();
      end
      OP_JR: begin
        cyc("jalr", ctl(0,0,0,0,1,0,2'b10,2'b10,2'b01,A_ADD,2'b00), 1'b0);
        cyc("jalrlink", ctl(0,0,0,0,0,1,2'b10,2'b01,2'b10,A_ADD,2'b00), 1'b0);
        retire();
      end
      default: trap_ph(2'b01);
    endcase
  endtask

  // asynchronous reset asserted mid-cycle must take effect before any clock edge
  task automatic reset_mid(input string nm);
    #2 RST = 1'b1;
    #1;
    chk({nm, "_memreq"},   32'(MemReq),    32'd1);
    chk({nm, "_memwrite"}, 32'(MemWrite),  32'd0);
    chk({nm, "_adrsrc"},   32'(AdrSrc),    32'd0);
    chk({nm, "_trap"},     32'(Trap),      32'd0);
    chk({nm, "_cause"},    32'(TrapCause), 32'd0);
    chk({nm, "_instret"},  32'(InstRet),   32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_ret = 0; m_cause = 2'b00; m_trap = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int c0;
    alu_tbl  = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    r_f3s    = '{3'd7, 3'd6, 3'd4, 3'd2, 3'd1, 3'd5};
    b_f3s    = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    flag_pat = '{4'b1010, 4'b0100, 4'b0101};
    RST = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0;
    Zero = 1'b0; N = 1'b0; C = 1'b0; V = 1'b0; MemReady = 1'b0;

    @(negedge CLK);
    chk("rst_memreq",    32'(MemReq),    32'd1);
    chk("rst_alusrcb",   32'(ALUSrcB),   32'd2);
    chk("rst_resultsrc", 32'(ResultSrc), 32'd2);
    chk("rst_irwrite",   32'(IRWrite),   32'd0);
    chk("rst_trap",      32'(Trap),      32'd0);
    chk("rst_instret",   32'(InstRet),   32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    c0 = m_cyc;
    run(OP_R, 3'd0, 1'b0, 0, 0);
    chk("add_cycles", 32'(m_cyc - c0), 32'd4);
    chk("add_instret", 32'(InstRet), 32'd1);
    run(OP_R, 3'd0, 1'b1, 0, 0);
    for (int i = 0; i < 6; i++) run(OP_R, r_f3s[i], 1'b0, 0, 0);
    run(OP_I, 3'd0, 1'b1, 15, 0);
    run(OP_I, 3'd4, 1'b0, 0, 0);

    c0 = m_cyc;
    run(OP_LD, 3'd2, 1'b0, 0, 3);
    chk("lw_cycles", 32'(m_cyc - c0), 32'd8);
    chk("lw_instret", 32'(InstRet), 32'd11);
    run(OP_ST, 3'd2, 1'b0, 2, 1);

    for (int p = 0; p < 3; p++) begin
      {Zero, N, C, V} = flag_pat[p];
      for (int i = 0; i < 6; i++) run(OP_BR, b_f3s[i], 1'b0, 0, 0);
    end
    run(OP_JAL, 3'd0, 1'b0, 0, 0);
    while ((m_total % 16) != 0) run(OP_R, 3'd0, 1'b0, 0, 0);
    chk("wrap_instret", 32'(InstRet), 32'd0);
    run(OP_JR, 3'd0, 1'b0, 0, 0);
    chk("jalr_instret", 32'(InstRet), 32'd1);

    run(OP_BR, 3'd2, 1'b0, 0, 0);
    reset_mid("br010");
    run(OP_R, 3'd3, 1'b0, 0, 0);
    reset_mid("r011");
    run(OP_BAD, 3'd0, 1'b0, 0, 0);
    reset_mid("undef");

    op = OP_ST; funct3 = 3'd2;
    fetch_ph(0);
    decode_ph(OP_ST);
    cyc("memadr", ctl(0,0,0,0,0,0,2'b00,2'b10,2'b01,A_ADD,2'b01), 1'b0);
    cyc("memwrite", ctl(1,1,1,0,0,0,2'b00,2'b00,2'b00,A_ADD,2'b00), 1'b0);
    reset_mid("sw_abort");

    for (int i = 0; i < 16; i++)
      cyc("fetch_wait", ctl(1,0,0,0,0,0,2'b10,2'b00,2'b10,A_ADD,2'b00), 1'b0);
    trap_ph(2'b10);
    reset_mid("timeout");
    run(OP_R, 3'd0, 1'b0, 0, 0);
    chk("recover_instret", 32'(InstRet), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
